// File: rtl/matmult_chan_pkg.sv
// Shared types and default sizing for the MatMult channel memory.
package matmult_chan_pkg;

   // Who currently owns the channel buffer.
   typedef enum logic {
      HOST_OWN = 1'b0,
      ENG_OWN  = 1'b1
   } own_state_e;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH = 7;
   localparam int DEF_DEPTH      = 100;

endpackage

// File: rtl/matmult_chan_mem_if.sv
// Engine and host access ports of one channel memory.
interface matmult_chan_mem_if
   import matmult_chan_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
   // engine side
   logic                  eng_re;
   logic [ADDR_WIDTH-1:0] eng_radr;
   logic [DATA_WIDTH-1:0] eng_q;
   logic                  eng_we;
   logic [ADDR_WIDTH-1:0] eng_wadr;
   logic [DATA_WIDTH-1:0] eng_d;
   logic                  eng_req_vz;
   logic                  eng_rls_lz;
   // host side
   logic                  host_re;
   logic [ADDR_WIDTH-1:0] host_radr;
   logic [DATA_WIDTH-1:0] host_q;
   logic                  host_we;
   logic [ADDR_WIDTH-1:0] host_wadr;
   logic [DATA_WIDTH-1:0] host_d;
   logic                  host_commit;
   logic                  host_busy;
   logic                  err;
   logic                  err_clr;

   // Requesters (engine and host) drive accesses.
   modport master (
      output eng_re, eng_radr, eng_we, eng_wadr, eng_d, eng_rls_lz,
      output host_re, host_radr, host_we, host_wadr, host_d, host_commit, err_clr,
      input  eng_q, eng_req_vz, host_q, host_busy, err
   );

   // The memory responds.
   modport slave (
      input  eng_re, eng_radr, eng_we, eng_wadr, eng_d, eng_rls_lz,
      input  host_re, host_radr, host_we, host_wadr, host_d, host_commit, err_clr,
      output eng_q, eng_req_vz, host_q, host_busy, err
   );
endinterface

// File: rtl/matmult_ram_1r1w.sv
// Storage array: one registered read port, one write port, read-first.
module matmult_ram_1r1w
   import matmult_chan_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] radr,
   output logic [DATA_WIDTH-1:0] q,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wadr,
   input  logic [DATA_WIDTH-1:0] d
);
   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] q_reg;

   // Write and registered read; the read samples the pre-write word.
   always_ff @(posedge clk) begin
      if (we) mem[wadr] <= d;
      if (re) q_reg <= mem[radr];
   end

   assign q = q_reg;
endmodule

// File: rtl/matmult_chan_mem.sv
// Channel memory: ownership FSM, owner muxing, range checks, per-side q and err.
module matmult_chan_mem
   import matmult_chan_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             arst_n,
   matmult_chan_mem_if.slave bus
);
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

   own_state_e            state_reg;
   logic                  eng_req_vz_reg;
   logic                  err_reg;
   logic                  eng_sel_reg, host_sel_reg;
   logic [DATA_WIDTH-1:0] eng_hold_reg, host_hold_reg;

   logic                  eng_own;
   logic                  eng_rin, eng_win, host_rin, host_win;
   logic                  eng_rd_ok, eng_rd_oor, host_rd_ok, host_rd_oor;
   logic                  err_set;
   logic                  ram_re, ram_we;
   logic [ADDR_WIDTH-1:0] ram_radr, ram_wadr;
   logic [DATA_WIDTH-1:0] ram_d, ram_q;
   logic [DATA_WIDTH-1:0] eng_q_cur, host_q_cur;

   assign eng_own  = (state_reg == ENG_OWN);

   assign eng_rin  = ({1'b0, bus.eng_radr}  < DEPTH_W);
   assign eng_win  = ({1'b0, bus.eng_wadr}  < DEPTH_W);
   assign host_rin = ({1'b0, bus.host_radr} < DEPTH_W);
   assign host_win = ({1'b0, bus.host_wadr} < DEPTH_W);

   // Only the owning side's reads count; out-of-range owner reads load zero.
   assign eng_rd_ok   =  eng_own & bus.eng_re  &  eng_rin;
   assign eng_rd_oor  =  eng_own & bus.eng_re  & ~eng_rin;
   assign host_rd_ok  = ~eng_own & bus.host_re &  host_rin;
   assign host_rd_oor = ~eng_own & bus.host_re & ~host_rin;

   assign ram_re   = eng_rd_ok | host_rd_ok;
   assign ram_radr = eng_own ? bus.eng_radr : bus.host_radr;
   assign ram_we   = eng_own ? (bus.eng_we & eng_win) : (bus.host_we & host_win);
   assign ram_wadr = eng_own ? bus.eng_wadr : bus.host_wadr;
   assign ram_d    = eng_own ? bus.eng_d    : bus.host_d;

   // Non-owner access, owner out-of-range access, or a commit while engine owns.
   assign err_set = (~eng_own & (bus.eng_re  | bus.eng_we))
                  | ( eng_own & (bus.host_re | bus.host_we | bus.host_commit))
                  | eng_rd_oor | host_rd_oor
                  | ( eng_own & bus.eng_we  & ~eng_win)
                  | (~eng_own & bus.host_we & ~host_win);

   matmult_ram_1r1w #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DEPTH     (DEPTH)
   ) u_ram (
      .clk (clk),
      .re  (ram_re),
      .radr(ram_radr),
      .q   (ram_q),
      .we  (ram_we),
      .wadr(ram_wadr),
      .d   (ram_d)
   );

   // Ownership hand-off between host and engine.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_reg      <= HOST_OWN;
         eng_req_vz_reg <= 1'b0;
      end else begin
         case (state_reg)
            HOST_OWN: if (bus.host_commit) begin
               state_reg      <= ENG_OWN;
               eng_req_vz_reg <= 1'b1;
            end
            ENG_OWN: if (bus.eng_rls_lz) begin
               state_reg      <= HOST_OWN;
               eng_req_vz_reg <= 1'b0;
            end
            default: begin
               state_reg      <= HOST_OWN;
               eng_req_vz_reg <= 1'b0;
            end
         endcase
      end
   end

   // Sticky error; a new error wins over a simultaneous clear.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) err_reg <= 1'b0;
      else         err_reg <= err_set | (err_reg & ~bus.err_clr);
   end

   // Per-side q: a good read shows the RAM port, otherwise the last shown value is held.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         eng_sel_reg   <= 1'b0;
         eng_hold_reg  <= '0;
         host_sel_reg  <= 1'b0;
         host_hold_reg <= '0;
      end else begin
         eng_sel_reg   <= eng_rd_ok;
         eng_hold_reg  <= eng_rd_oor ? '0 : eng_q_cur;
         host_sel_reg  <= host_rd_ok;
         host_hold_reg <= host_rd_oor ? '0 : host_q_cur;
      end
   end

   assign eng_q_cur  = eng_sel_reg  ? ram_q : eng_hold_reg;
   assign host_q_cur = host_sel_reg ? ram_q : host_hold_reg;

   assign bus.eng_q      = eng_q_cur;
   assign bus.host_q     = host_q_cur;
   assign bus.eng_req_vz = eng_req_vz_reg;
   assign bus.host_busy  = eng_req_vz_reg;
   assign bus.err        = err_reg;
endmodule

// File: doc/matmult_chan_mem.md
# matmult_chan_mem

Responder-side channel memory for the MatMult accelerator: a synchronous single-read/single-write RAM that services the engine's `radr/re/q` read ports and `wadr/we/d` write port, and owns the `req_vz`/`rls_lz` buffer handshake. A host port fills the buffer and hands it to the engine, then reads results back once the engine releases it. One instance sits behind each of the a, b and c channels of the MatMult top level.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: word width.
- `ADDR_WIDTH`, default 7: address width.
- `DEPTH`, default 100: valid words, addresses 0..DEPTH-1.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `arst_n`  in  1  asynchronous active-low reset.
- `eng_re`  in  1  engine read enable.
- `eng_radr`  in  ADDR_WIDTH  engine read address.
- `eng_q`  out  DATA_WIDTH  engine read data, registered.
- `eng_we`  in  1  engine write enable.
- `eng_wadr`  in  ADDR_WIDTH  engine write address.
- `eng_d`  in  DATA_WIDTH  engine write data.
- `eng_req_vz`  out  1  buffer granted to engine.
- `eng_rls_lz`  in  1  engine release pulse.
- `host_re`  in  1  host read enable.
- `host_radr`  in  ADDR_WIDTH  host read address.
- `host_q`  out  DATA_WIDTH  host read data, registered.
- `host_we`  in  1  host write enable.
- `host_wadr`  in  ADDR_WIDTH  host write address.
- `host_d`  in  DATA_WIDTH  host write data.
- `host_commit`  in  1  hand buffer to engine.
- `host_busy`  out  1  engine owns buffer (equals `eng_req_vz`).
- `err`  out  1  sticky protocol/address error.
- `err_clr`  in  1  clears `err`.

## Operation
- Ownership FSM, two states:
  - HOST_OWN: the reset state.
  - ENG_OWN.
- HOST_OWN -> ENG_OWN when `host_commit`=1.
- ENG_OWN -> HOST_OWN when `eng_rls_lz`=1.
- `eng_req_vz` = (state == ENG_OWN). It is a registered output.
- Only the owner's read and write ports reach the array.
  - A non-owner `re` or `we` is ignored: no array write, and that side's `q` holds its value.
  - A non-owner access sets `err`.
- Out-of-range address (>= DEPTH):
  - A write is dropped.
  - A read loads `q` with 0.
  - Either case sets `err`.
- `host_commit` in ENG_OWN is ignored and sets `err`.
- `eng_rls_lz` in HOST_OWN is ignored; it does not set `err`.
- `err` is sticky until `err_clr`. If `err_clr` and a new error occur in the same cycle, `err` = 1.
- Same-address read and write in the same cycle is read-first: `q` returns the old word.
- Reads with `re`=0 hold `q`.
- No arithmetic. Addresses are compared unsigned against DEPTH.

## Timing
- Reset values: state HOST_OWN, `eng_req_vz`=0, `host_busy`=0, `eng_q`=0, `host_q`=0, `err`=0. Array contents are not reset.
- Read latency is 1 cycle: address and `re` at edge N give `q` valid after edge N.
- A write at edge N is visible to a read issued at edge N+1.
- `host_commit` at edge N gives `eng_req_vz`=1 after edge N.
  - A host write in the same cycle as `host_commit` is performed (write, then hand-off).
  - The engine can access from edge N+1.
- `eng_rls_lz` at edge N gives `eng_req_vz`=0 after edge N.
  - An engine write in the same cycle is performed.
  - The host can access from edge N+1.
- Reset mid-operation: state returns to HOST_OWN immediately and asynchronously; outputs take reset values; no pending access completes.

## Structure
- Package `matmult_chan_pkg` holds:
  - the owner-state enum (HOST_OWN, ENG_OWN);
  - default DATA_WIDTH, ADDR_WIDTH, DEPTH constants.
- Sub-module `matmult_ram_1r1w`:
  - storage array with one registered read port and one write port;
  - read-first semantics.
- The top block holds the FSM, owner muxing, range checks, the per-side `q` registers and `err`.

## Test plan
- Reset, then host writes 0x1234 at address 5, commits, and the engine reads address 5: `eng_req_vz`=1 after the commit edge, then `eng_q`=0x1234 one cycle after `eng_re`, and `err`=0.
- Engine writes 0xBEEF at address 99 and pulses `eng_rls_lz` in the same cycle; host then reads address 99 → `eng_req_vz`=0 next cycle, and `host_q`=0xBEEF.
- Engine reads and writes address 10 in the same cycle, old value 0x0001, new value 0x0002 → `eng_q`=0x0001; the next read returns 0x0002.
- Host writes address 100 while owning, then reads address 127 → the array is unchanged, `host_q`=0, `err`=1 and stays set until `err_clr`.
- `host_commit` while in ENG_OWN, and a host write while the engine owns the buffer → both are ignored, the array is unchanged, and `err`=1.
- Drop `arst_n` while in ENG_OWN with `eng_q`=0xBEEF → `eng_req_vz`=0, `eng_q`=0, `host_busy`=0 immediately without a clock edge, and the next `host_commit` is accepted normally.
